// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared encodings for the memory-stage data-bus controller: memory op codes,
// bus size codes and the controller state type.
package mem_dbus_ctrl_pkg;

    localparam logic [3:0] MOP_NONE = 4'd0;
    localparam logic [3:0] MOP_LB   = 4'd1;
    localparam logic [3:0] MOP_LBU  = 4'd2;
    localparam logic [3:0] MOP_LH   = 4'd3;
    localparam logic [3:0] MOP_LHU  = 4'd4;
    localparam logic [3:0] MOP_LW   = 4'd5;
    localparam logic [3:0] MOP_SB   = 4'd6;
    localparam logic [3:0] MOP_SH   = 4'd7;
    localparam logic [3:0] MOP_SW   = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        DBS_IDLE       = 3'd0,
        DBS_REQ        = 3'd1,
        DBS_WAIT       = 3'd2,
        DBS_DONE       = 3'd3,
        DBS_DRAIN_REQ  = 3'd4,
        DBS_DRAIN_WAIT = 3'd5
    } dbs_state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes/replicated data on the request
// side, byte/half extraction with sign or zero extension on the response side.
module mem_align
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wsrc,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the naturally aligned word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Per-op size, strobes, store data and extended load result.
    always_comb begin
        size  = SIZE_WORD;
        wstrb = 4'b0000;
        wdata = 32'd0;
        ldata = rdata;
        case (op)
            MOP_LB: begin
                size  = SIZE_BYTE;
                ldata = {{24{byte_sel[7]}}, byte_sel};
            end
            MOP_LBU: begin
                size  = SIZE_BYTE;
                ldata = {24'd0, byte_sel};
            end
            MOP_LH: begin
                size  = SIZE_HALF;
                ldata = {{16{half_sel[15]}}, half_sel};
            end
            MOP_LHU: begin
                size  = SIZE_HALF;
                ldata = {16'd0, half_sel};
            end
            MOP_SB: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{wsrc[7:0]}};
            end
            MOP_SH: begin
                size  = SIZE_HALF;
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wsrc[15:0]}};
            end
            MOP_SW: begin
                wstrb = 4'b1111;
                wdata = wsrc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: issues one SRAM-like bus transaction per
// slot-1 load/store, stalls the pipe until it completes, and drains
// outstanding transactions when a flush abandons the access.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no access in flight; accept a new load/store
// REQ        | req asserted, waiting for addr_ok
// WAIT       | address accepted, waiting for data_ok
// DONE       | access complete, load result valid until the pipe advances
// DRAIN_REQ  | flushed while requesting; req held until addr_ok
// DRAIN_WAIT | flushed after address phase; discard the coming data_ok
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic        exc_i,
    input  logic        flush_i,
    input  logic        advance_i,
    output logic        stallreq_o,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i
);

    dbs_state_t  state, state_nxt;
    logic [3:0]  lat_op;
    logic [1:0]  lat_lo;
    logic        go, latch_req, latch_load;
    logic        half_op_ld, half_op_st, mis_half, mis_word;

    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] req_ldata_unused;
    logic [1:0]  rsp_size_unused;
    logic [3:0]  rsp_wstrb_unused;
    logic [31:0] rsp_wdata_unused;
    logic [31:0] rsp_ldata;

    mem_align u_req_align (
        .op      (mem_op_i),
        .addr_lo (mem_addr_i[1:0]),
        .wsrc    (reg2_i),
        .rdata   (32'd0),
        .size    (req_size),
        .wstrb   (req_wstrb),
        .wdata   (req_wdata),
        .ldata   (req_ldata_unused)
    );

    mem_align u_rsp_align (
        .op      (lat_op),
        .addr_lo (lat_lo),
        .wsrc    (32'd0),
        .rdata   (data_rdata_i),
        .size    (rsp_size_unused),
        .wstrb   (rsp_wstrb_unused),
        .wdata   (rsp_wdata_unused),
        .ldata   (rsp_ldata)
    );

    // Alignment errors are reported combinationally and block the access.
    assign half_op_ld = (mem_op_i == MOP_LH) || (mem_op_i == MOP_LHU);
    assign half_op_st = (mem_op_i == MOP_SH);
    assign mis_half   = mem_addr_i[0];
    assign mis_word   = |mem_addr_i[1:0];
    assign adel_o = valid_i & ~exc_i &
                    ((half_op_ld & mis_half) | ((mem_op_i == MOP_LW) & mis_word));
    assign ades_o = valid_i & ~exc_i &
                    ((half_op_st & mis_half) | ((mem_op_i == MOP_SW) & mis_word));
    assign go = valid_i & (mem_op_i != MOP_NONE) & ~exc_i & ~adel_o & ~ades_o & ~flush_i;

    // Next-state, stall request and latch enables; flush wins over bus handshakes.
    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        latch_req  = 1'b0;
        latch_load = 1'b0;
        case (state)
            DBS_IDLE: begin
                stallreq_o = go;
                if (go) begin
                    latch_req = 1'b1;
                    state_nxt = DBS_REQ;
                end
            end
            DBS_REQ: begin
                stallreq_o = 1'b1;
                if (flush_i)
                    state_nxt = data_addr_ok_i ? DBS_DRAIN_WAIT : DBS_DRAIN_REQ;
                else if (data_addr_ok_i)
                    state_nxt = DBS_WAIT;
            end
            DBS_WAIT: begin
                stallreq_o = 1'b1;
                if (flush_i)
                    state_nxt = data_data_ok_i ? DBS_IDLE : DBS_DRAIN_WAIT;
                else if (data_data_ok_i) begin
                    latch_load = 1'b1;
                    state_nxt  = DBS_DONE;
                end
            end
            DBS_DONE: begin
                if (advance_i || flush_i)
                    state_nxt = DBS_IDLE;
            end
            DBS_DRAIN_REQ: begin
                stallreq_o = valid_i;
                if (data_addr_ok_i)
                    state_nxt = DBS_DRAIN_WAIT;
            end
            DBS_DRAIN_WAIT: begin
                stallreq_o = valid_i;
                if (data_data_ok_i)
                    state_nxt = DBS_IDLE;
            end
            default: state_nxt = DBS_IDLE;
        endcase
    end

    // State register plus registered bus fields and load result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= DBS_IDLE;
            lat_op       <= MOP_NONE;
            lat_lo       <= 2'd0;
            data_req_o   <= 1'b0;
            data_wr_o    <= 1'b0;
            data_size_o  <= SIZE_BYTE;
            data_addr_o  <= 32'd0;
            data_wstrb_o <= 4'd0;
            data_wdata_o <= 32'd0;
            load_valid_o <= 1'b0;
            load_data_o  <= 32'd0;
        end else begin
            state        <= state_nxt;
            data_req_o   <= (state_nxt == DBS_REQ) || (state_nxt == DBS_DRAIN_REQ);
            load_valid_o <= (state_nxt == DBS_DONE);
            if (latch_req) begin
                lat_op       <= mem_op_i;
                lat_lo       <= mem_addr_i[1:0];
                data_wr_o    <= is_store(mem_op_i);
                data_size_o  <= req_size;
                data_addr_o  <= mem_addr_i;
                data_wstrb_o <= req_wstrb;
                data_wdata_o <= req_wdata;
            end
            if (latch_load)
                load_data_o <= rsp_ldata;
        end
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl with a scoreboard: expected bus requests
// and load results are queued by the stimulus and checked by a monitor.
module tb_mem_dbus_ctrl;
    import mem_dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic        exc_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        advance_i = 1'b0;
    logic        stallreq_o, load_valid_o, adel_o, ades_o;
    logic [31:0] load_data_o;
    logic        data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i = 1'b0;
    logic        data_data_ok_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    mem_dbus_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .mem_op_i       (mem_op_i),
        .mem_addr_i     (mem_addr_i),
        .reg2_i         (reg2_i),
        .exc_i          (exc_i),
        .flush_i        (flush_i),
        .advance_i      (advance_i),
        .stallreq_o     (stallreq_o),
        .load_valid_o   (load_valid_o),
        .load_data_o    (load_data_o),
        .adel_o         (adel_o),
        .ades_o         (ades_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } ld_t;

    req_t req_q[$];
    ld_t  ld_q[$];
    req_t me;
    ld_t  ml;
    logic lv_prev = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted request and every new load result pops the scoreboard.
    always @(negedge clk) begin
        if (rst && data_req_o && data_addr_ok_i) begin
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected act=addr %0h exp=none", data_addr_o);
            end else begin
                me = req_q.pop_front();
                chk("req_wr",    {31'd0, data_wr_o},    {31'd0, me.wr});
                chk("req_size",  {30'd0, data_size_o},  {30'd0, me.size});
                chk("req_addr",  data_addr_o,           me.addr);
                chk("req_wstrb", {28'd0, data_wstrb_o}, {28'd0, me.wstrb});
                chk("req_wdata", data_wdata_o,          me.wdata);
            end
        end
        if (load_valid_o && !lv_prev) begin
            if (ld_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL load_unexpected act=%0h exp=none", load_data_o);
            end else begin
                ml = ld_q.pop_front();
                if (ml.chk)
                    chk("load_data", load_data_o, ml.data);
            end
        end
        lv_prev <= load_valid_o;
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req"},   {31'd0, data_req_o},   32'd0);
        chk({tag, "_wr"},    {31'd0, data_wr_o},    32'd0);
        chk({tag, "_size"},  {30'd0, data_size_o},  32'd0);
        chk({tag, "_addr"},  data_addr_o,           32'd0);
        chk({tag, "_wstrb"}, {28'd0, data_wstrb_o}, 32'd0);
        chk({tag, "_wdata"}, data_wdata_o,          32'd0);
        chk({tag, "_lv"},    {31'd0, load_valid_o}, 32'd0);
        chk({tag, "_ldata"}, load_data_o,           32'd0);
        chk({tag, "_stall"}, {31'd0, stallreq_o},   32'd0);
    endtask

    // One complete access from IDLE: a_dly idle cycles before addr_ok,
    // d_dly cycles in WAIT before data_ok, hold extra DONE cycles before advance.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rdata,
                              input logic e_wr, input logic [1:0] e_size,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                              input logic is_load, input logic [31:0] e_load,
                              input int a_dly, input int d_dly, input int hold);
        req_q.push_back({e_wr, e_size, addr, e_wstrb, e_wdata});
        ld_q.push_back({is_load, e_load});
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; reg2_i = reg2;
        #1;
        chk("c0_stall", {31'd0, stallreq_o}, 32'd1);
        chk("c0_req",   {31'd0, data_req_o}, 32'd0);
        tick(); #1;
        chk("c1_req",   {31'd0, data_req_o}, 32'd1);
        chk("c1_stall", {31'd0, stallreq_o}, 32'd1);
        for (int i = 0; i < a_dly; i++) begin
            tick(); #1;
            chk("req_hold", {31'd0, data_req_o}, 32'd1);
        end
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        #1;
        chk("wait_req", {31'd0, data_req_o}, 32'd0);
        chk("wait_stall", {31'd0, stallreq_o}, 32'd1);
        for (int i = 0; i < d_dly; i++) begin
            tick(); #1;
            chk("wait_stall", {31'd0, stallreq_o}, 32'd1);
        end
        data_data_ok_i = 1'b1; data_rdata_i = rdata;
        tick();
        data_data_ok_i = 1'b0; data_rdata_i = 32'hDEAD_0BAD;
        for (int i = 0; i <= hold; i++) begin
            #1;
            chk("done_lv",    {31'd0, load_valid_o}, 32'd1);
            chk("done_stall", {31'd0, stallreq_o},   32'd0);
            chk("done_req",   {31'd0, data_req_o},   32'd0);
            if (is_load) chk("done_ldata", load_data_o, e_load);
            if (i < hold) tick();
        end
        advance_i = 1'b1;
        tick();
        advance_i = 1'b0; valid_i = 1'b0; mem_op_i = MOP_NONE;
        #1;
        chk("after_lv", {31'd0, load_valid_o}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outs("rst0");
        rst = 1'b1;
        tick();

        // Directed load/store vectors, hand-computed expectations.
        run_access(MOP_SW,  32'h8000_0004, 32'h1234_5678, 32'h0000_0000,
                   1'b1, SIZE_WORD, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 0, 1, 0);
        run_access(MOP_LB,  32'h8000_0003, 32'hDEAD_BEEF, 32'h80AA_BBCC,
                   1'b0, SIZE_BYTE, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80, 0, 0, 0);
        run_access(MOP_LBU, 32'h8000_0003, 32'h0, 32'h80AA_BBCC,
                   1'b0, SIZE_BYTE, 4'b0000, 32'h0, 1'b1, 32'h0000_0080, 1, 0, 0);
        run_access(MOP_LH,  32'h8000_0002, 32'h0, 32'h80AA_BBCC,
                   1'b0, SIZE_HALF, 4'b0000, 32'h0, 1'b1, 32'hFFFF_80AA, 0, 2, 0);
        run_access(MOP_LHU, 32'h8000_0000, 32'h0, 32'h80AA_BBCC,
                   1'b0, SIZE_HALF, 4'b0000, 32'h0, 1'b1, 32'h0000_BBCC, 0, 0, 0);
        run_access(MOP_LW,  32'h8000_0000, 32'h0, 32'h80AA_BBCC,
                   1'b0, SIZE_WORD, 4'b0000, 32'h0, 1'b1, 32'h80AA_BBCC, 0, 0, 0);
        run_access(MOP_LB,  32'h8000_0000, 32'h0, 32'h0000_007F,
                   1'b0, SIZE_BYTE, 4'b0000, 32'h0, 1'b1, 32'h0000_007F, 0, 0, 0);
        run_access(MOP_SB,  32'h8000_0001, 32'h0000_00A5, 32'h0,
                   1'b1, SIZE_BYTE, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0, 0, 0, 0);
        run_access(MOP_SH,  32'h8000_0002, 32'h1234_BEEF, 32'h0,
                   1'b1, SIZE_HALF, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 0, 0, 0);

        // Misaligned accesses: error same cycle, never a request.
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0002;
        #1;
        chk("lw_mis_adel",  {31'd0, adel_o},     32'd1);
        chk("lw_mis_ades",  {31'd0, ades_o},     32'd0);
        chk("lw_mis_stall", {31'd0, stallreq_o}, 32'd0);
        tick(); #1;
        chk("lw_mis_req", {31'd0, data_req_o}, 32'd0);
        mem_op_i = MOP_LHU; mem_addr_i = 32'h8000_0003;
        #1;
        chk("lhu_mis_adel", {31'd0, adel_o}, 32'd1);
        mem_op_i = MOP_SH; mem_addr_i = 32'h8000_0001;
        #1;
        chk("sh_mis_ades",  {31'd0, ades_o},     32'd1);
        chk("sh_mis_adel",  {31'd0, adel_o},     32'd0);
        chk("sh_mis_stall", {31'd0, stallreq_o}, 32'd0);
        tick(); #1;
        chk("sh_mis_req", {31'd0, data_req_o}, 32'd0);
        mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0002; exc_i = 1'b1;
        #1;
        chk("exc_adel",  {31'd0, adel_o},     32'd0);
        chk("exc_stall", {31'd0, stallreq_o}, 32'd0);
        tick(); #1;
        chk("exc_req", {31'd0, data_req_o}, 32'd0);
        exc_i = 1'b0; valid_i = 1'b0; mem_op_i = MOP_NONE;
        tick();

        // Flush in REQ, addr_ok two cycles late: req held, data discarded.
        req_q.push_back({1'b0, SIZE_WORD, 32'h8000_0008, 4'h0, 32'h0});
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0008;
        tick();
        flush_i = 1'b1; valid_i = 1'b0; mem_op_i = MOP_NONE;
        tick();
        flush_i = 1'b0;
        #1;
        chk("drq_req1",   {31'd0, data_req_o}, 32'd1);
        chk("drq_stall1", {31'd0, stallreq_o}, 32'd0);
        tick(); #1;
        chk("drq_req2", {31'd0, data_req_o}, 32'd1);
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        #1;
        chk("drw_req", {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h1111_1111;
        tick();
        data_data_ok_i = 1'b0;
        #1;
        chk("drain_lv0", {31'd0, load_valid_o}, 32'd0);
        tick(); #1;
        chk("drain_lv1", {31'd0, load_valid_o}, 32'd0);

        // New load arriving during DRAIN_WAIT waits for the drain data_ok.
        req_q.push_back({1'b0, SIZE_WORD, 32'h8000_0010, 4'h0, 32'h0});
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0010;
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0; flush_i = 1'b1; valid_i = 1'b0; mem_op_i = MOP_NONE;
        tick();
        flush_i = 1'b0; valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0014;
        #1;
        chk("dw_new_stall0", {31'd0, stallreq_o}, 32'd1);
        chk("dw_new_req0",   {31'd0, data_req_o}, 32'd0);
        tick(); #1;
        chk("dw_new_stall1", {31'd0, stallreq_o}, 32'd1);
        chk("dw_new_req1",   {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h2222_2222;
        tick();
        data_data_ok_i = 1'b0;
        run_access(MOP_LW, 32'h8000_0014, 32'h0, 32'hCAFE_F00D,
                   1'b0, SIZE_WORD, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 1, 0, 0);

        // addr_ok+flush in REQ goes straight to DRAIN_WAIT (req drops).
        req_q.push_back({1'b0, SIZE_WORD, 32'h8000_0018, 4'h0, 32'h0});
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0018;
        tick();
        data_addr_ok_i = 1'b1; flush_i = 1'b1; valid_i = 1'b0; mem_op_i = MOP_NONE;
        tick();
        data_addr_ok_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("aokfl_req", {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        #1;
        chk("aokfl_lv", {31'd0, load_valid_o}, 32'd0);

        // data_ok+flush in WAIT returns to IDLE; the next access starts at once.
        req_q.push_back({1'b0, SIZE_WORD, 32'h8000_001C, 4'h0, 32'h0});
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_001C;
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; flush_i = 1'b1; valid_i = 1'b0;
        mem_op_i = MOP_NONE;
        tick();
        data_data_ok_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("dokfl_lv", {31'd0, load_valid_o}, 32'd0);

        // DONE held three cycles: one request, stable data.
        run_access(MOP_LW, 32'h8000_0024, 32'h0, 32'h0BAD_CAFE,
                   1'b0, SIZE_WORD, 4'b0000, 32'h0, 1'b1, 32'h0BAD_CAFE, 0, 0, 3);

        // Reset asserted in WAIT.
        req_q.push_back({1'b0, SIZE_WORD, 32'h8000_0020, 4'h0, 32'h0});
        valid_i = 1'b1; mem_op_i = MOP_LW; mem_addr_i = 32'h8000_0020;
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0; rst = 1'b0; valid_i = 1'b0; mem_op_i = MOP_NONE;
        tick();
        check_reset_outs("rst_wait");
        rst = 1'b1;
        tick(); tick();

        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("ld_q_empty",  32'(ld_q.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dbus_ctrl.md
# mem_dbus_ctrl

Memory-stage data-bus controller, the consumer of the EX/MEM pipeline register. It takes the load/store carried by slot 1 of the memory stage, checks alignment, and drives one transaction on the SRAM-like data bus (req/addr_ok/data_ok). It holds the pipeline with a stall request until the access completes, and returns aligned, extended load data. It also drains in-flight bus transactions safely when an exception flush arrives.

## Interface
Parameters: none. Op and state encodings come from `defines.v`.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- valid_i  in  1  slot-1 instruction in MEM performs a memory access
- mem_op_i  in  4  `MOP_LB/LBU/LH/LHU/LW/SB/SH/SW`; `MOP_NONE`=0
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store source data
- exc_i  in  1  instruction already carries an exception; no bus access
- flush_i  in  1  exception flush; abandon current access
- advance_i  in  1  MEM input register loads a new instruction at this edge
- stallreq_o  out  1  hold pipeline; combinational
- load_valid_o  out  1  load_data_o valid; reset 0
- load_data_o  out  32  aligned/extended load result; reset 0
- adel_o  out  1  load address error; combinational
- ades_o  out  1  store address error; combinational
- data_req_o  out  1  bus request; registered, reset 0
- data_wr_o  out  1  1 = store; reset 0
- data_size_o  out  2  0 byte, 1 half, 2 word; reset 0
- data_addr_o  out  32  mem_addr_i, unmodified; reset 0
- data_wstrb_o  out  4  byte strobes; reset 0
- data_wdata_o  out  32  replicated store data; reset 0
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  response (rdata / write ack)
- data_rdata_i  in  32  read data, naturally aligned word

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN_REQ, DRAIN_WAIT. Reset → IDLE.
- go = valid_i & op≠NONE & ~exc_i & ~adel_o & ~ades_o & ~flush_i.
- IDLE: go → latch bus fields and load-op info, go to REQ.
- REQ: data_req_o=1. addr_ok → WAIT. flush_i → DRAIN_REQ, keeping req asserted; a request is never withdrawn.
- WAIT: data_ok → DONE, latching the aligned load result. flush_i → DRAIN_WAIT.
- DONE: load_valid_o=1. advance_i or flush_i → IDLE.
- DRAIN_REQ: addr_ok → DRAIN_WAIT.
- DRAIN_WAIT: data_ok → IDLE. The response is discarded and load_valid_o stays 0.
- stallreq_o = (go & state==IDLE) | state∈{REQ,WAIT} | (valid_i & state∈{DRAIN_REQ,DRAIN_WAIT}).
- Alignment errors:
  - adel_o = valid_i & ~exc_i & (LH/LHU & addr[0] | LW & addr[1:0]≠0).
  - ades_o is the same check for SH/SW.
  - Any error blocks the access; the error is reported the same cycle.
- Stores:
  - SB: wstrb=1<<addr[1:0], wdata={4{reg2[7:0]}}.
  - SH: wstrb=addr[1]?1100:0011, wdata={2{reg2[15:0]}}.
  - SW: wstrb=1111, wdata=reg2.
- Loads:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Bus fields other than req hold their value from latch until the next latch.

## Timing
- Cycle 0: op presented in IDLE, stallreq_o=1. Cycle 1: data_req_o=1. Minimum completion: addr_ok in cycle 1, data_ok in cycle 2, DONE and load_valid_o=1 in cycle 3 with stallreq_o=0.
- data_ok is sampled only in WAIT/DRAIN_WAIT. Same-cycle addr_ok+data_ok is not supported by the bus.
- flush_i has priority over addr_ok/data_ok for the destination state. From REQ with addr_ok+flush → DRAIN_WAIT. From WAIT with data_ok+flush → IDLE, data discarded.
- reset low mid-transaction forces IDLE with all outputs at reset values; the bus is reset with the core.
- No re-issue: the held instruction in DONE does not restart until advance_i.

## Structure
- `defines.v`: `MOP_*` codes, state codes `DBS_IDLE..DBS_DRAIN_WAIT` (3 bits), size codes.
- Sub-module `mem_align`: combinational store strobe/data generation and load extraction/extension; instantiated once for the request path and once for the response path.

## Test plan
- SW addr 0x8000_0004, reg2 0x1234_5678, addr_ok in cycle 1, data_ok in cycle 3 → wstrb 1111, wr=1, stallreq_o high cycles 0–3, low in cycle 4.
- LB addr 0x…03, rdata 0x80AA_BBCC → load_data_o 0xFFFF_FF80; LBU → 0x0000_0080; LH addr 0x…02 → 0xFFFF_80AA.
- LW addr 0x…02 → adel_o=1 same cycle, data_req_o never asserted, stallreq_o=0.
- flush_i in REQ with addr_ok delayed 2 cycles → req held until addr_ok, data_ok consumed, load_valid_o stays 0, back to IDLE.
- New load presented while in DRAIN_WAIT → stallreq_o=1, its req issued only after the drain data_ok.
- DONE held 3 cycles with advance_i=0 → exactly one bus request, load_data_o stable; reset asserted in WAIT → IDLE, all outputs 0 next cycle.
